// File: rtl/pcileech_tlp_pkg.sv
// Shared constants, FSM state type and slot helpers for the 128-byte TLP connector.
package pcileech_tlp_pkg;

  localparam int unsigned TLP_SLOT_W    = 66;
  localparam int unsigned TLP128_SLOTS  = 18;
  localparam int unsigned SLOT_LAST_BIT = 64;
  localparam int unsigned SLOT_KEEP_BIT = 65;
  localparam int unsigned TLP_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } tlp_tx_state_t;

  function automatic logic [7:0] slot_keep(input logic keep_dw2);
    return keep_dw2 ? 8'hFF : 8'h0F;
  endfunction

endpackage

// File: rtl/pcileech_tlp128_axis_tx.sv
// Fetches one packed TLP from the IfTlp128 source and serializes it as AXI-stream TX beats.
// Optional malformed-TLP counter enabled by PCILEECH_TLP128_MALFORMED_CNT_EN.
module pcileech_tlp128_axis_tx
  import pcileech_tlp_pkg::*;
#(
  parameter int unsigned MAX_QW = TLP128_SLOTS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [TLP_SLOT_W*MAX_QW-1:0]   tlp_data,
  input  logic                           tlp_valid,
  input  logic                           tlp_has_data,
  output logic                           tlp_req_data,
  output logic [63:0]                    tx_data,
  output logic [7:0]                     tx_keep,
  output logic                           tx_last,
  output logic                           tx_valid,
  input  logic                           tx_ready
`ifdef PCILEECH_TLP128_MALFORMED_CNT_EN
  ,
  output logic [15:0]                    err_cnt,
  output logic                           err_flag
`endif
);

  localparam logic [TLP_IDX_W-1:0] LAST_IDX = TLP_IDX_W'(MAX_QW - 1);

  tlp_tx_state_t                  r_state, w_state;
  logic                           r_req, w_req;
  logic                           r_valid, w_valid;
  logic [63:0]                    r_data, w_data;
  logic [7:0]                     r_keep, w_keep;
  logic                           r_last, w_last;
  logic [TLP_IDX_W-1:0]           r_idx, w_idx;
  logic [TLP_SLOT_W*MAX_QW-1:0]   r_buf, w_buf;

  logic                           w_load;
  logic [TLP_IDX_W-1:0]           w_idx_inc;
  logic [TLP_IDX_W-1:0]           w_ld_idx;
  logic [TLP_SLOT_W-1:0]          w_ld_slot;

  // Clamped so the part-select stays in range even when the last slot is showing.
  assign w_idx_inc = (r_idx == LAST_IDX) ? r_idx : r_idx + TLP_IDX_W'(1);

  // The first beat comes straight from the source bundle so it appears the cycle after capture.
  assign w_ld_idx  = (r_state == WAIT) ? '0 : w_idx_inc;
  assign w_ld_slot = (r_state == WAIT) ? tlp_data[TLP_SLOT_W-1:0]
                                       : r_buf[w_idx_inc*TLP_SLOT_W +: TLP_SLOT_W];

`ifdef PCILEECH_TLP128_MALFORMED_CNT_EN
  logic        r_forced, w_forced;
  logic [15:0] r_err_cnt;
`endif

  always_comb begin
    w_state = r_state;
    w_req   = 1'b0;
    w_valid = r_valid;
    w_data  = r_data;
    w_keep  = r_keep;
    w_last  = r_last;
    w_idx   = r_idx;
    w_buf   = r_buf;
    w_load  = 1'b0;
`ifdef PCILEECH_TLP128_MALFORMED_CNT_EN
    w_forced = r_forced;
`endif

    case (r_state)
      IDLE: begin
        if (tlp_has_data) begin
          w_req   = 1'b1;
          w_state = WAIT;
        end
      end
      WAIT: begin
        if (tlp_valid) begin
          w_buf   = tlp_data;
          w_idx   = '0;
          w_load  = 1'b1;
          w_state = SEND;
        end
      end
      SEND: begin
        if (r_valid && tx_ready) begin
          if (r_last) begin
            w_valid = 1'b0;
            w_state = IDLE;
          end else begin
            w_idx  = w_idx_inc;
            w_load = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_load) begin
      w_valid = 1'b1;
      w_data  = w_ld_slot[63:0];
      w_keep  = slot_keep(w_ld_slot[SLOT_KEEP_BIT]);
      w_last  = w_ld_slot[SLOT_LAST_BIT] | (w_ld_idx == LAST_IDX);
`ifdef PCILEECH_TLP128_MALFORMED_CNT_EN
      w_forced = (w_ld_idx == LAST_IDX) & ~w_ld_slot[SLOT_LAST_BIT];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_keep  <= w_keep;
      r_last  <= w_last;
      r_idx   <= w_idx;
      r_buf   <= w_buf;
    end
  end

  assign tlp_req_data = r_req;
  assign tx_valid     = r_valid;
  assign tx_data      = r_data;
  assign tx_keep      = r_keep;
  assign tx_last      = r_last;

`ifdef PCILEECH_TLP128_MALFORMED_CNT_EN
  // Gated by the live handshake so the pulse lands on the accepting cycle, even under stalls.
  assign err_flag = r_valid & tx_ready & r_forced;
  assign err_cnt  = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_forced  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_forced <= w_forced;
      if (err_flag && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
